alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle controller that computes the low 32 bits of an unsigned 32×32 product by sequencing the shared combinational ALU through shift-and-add iterations: ADD (Funct 00) to accumulate and SLL (Funct 10, Shamt 1) to advance the multiplicand. It sits beside the ALU in the datapath and borrows it only while busy, so a multiply needs no dedicated multiplier array. Operands enter and the product leaves through valid/ready handshakes.

## Interface
- DATA_W, 32: operand, accumulator and product width; fixed at 32, matching the ALU
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- Start_valid  in  1  operands present
- Start_ready  out  1  high only in IDLE; reset 1
- Multiplicand  in  32  operand A, sampled on accept
- Multiplier  in  32  operand B, sampled on accept
- Result_valid  out  1  high only in DONE; reset 0
- Result_ready  in  1  consumer accepts product
- Product  out  32  accumulator register; reset 0
- Busy  out  1  high in ADD or SHIFT; reset 0
- ALU_src_1  out  32  to ALU Src_1
- ALU_src_2  out  32  to ALU Src_2
- ALU_shamt  out  5  to ALU Shamt
- ALU_funct  out  2  to ALU Funct
- ALU_result  in  32  from ALU, combinational same cycle

## Operation
- States: IDLE, ADD, SHIFT, DONE. Registers: acc (32), mcand (32), mplier (32), cnt (6).
- IDLE, accept (Start_valid && Start_ready):
  - load mcand=Multiplicand, mplier=Multiplier, acc=0, cnt=0
  - next state is ADD if Multiplier[0]=1, else SHIFT
- ADD:
  - drive src_1=acc, src_2=mcand, shamt=0, funct=00
  - acc <= ALU_result; next state SHIFT
- SHIFT:
  - drive src_1=mcand, src_2=0, shamt=1, funct=10
  - mcand <= ALU_result; mplier <= mplier>>1; cnt <= cnt+1
  - if the loop is finished (see Configuration), next state DONE
  - otherwise next state ADD if the shifted mplier[0]=1, else SHIFT
- DONE: on Result_ready, go to IDLE. Product holds acc until the next accept.
- IDLE and DONE drive all ALU outputs to 0, with funct=00.
- Arithmetic: all sums and shifts wrap modulo 2^32. Bits above bit 31 are discarded and there is no overflow flag.
- Start_valid is ignored outside IDLE. Result_ready is ignored outside DONE.
- rst in any state, including mid-multiply, forces IDLE and clears acc, mcand, mplier and cnt. All outputs return to their reset values on the next edge.

## Timing
- ALU outputs are a combinational decode of the state and registers. ALU_result is captured at the end of the same cycle.
- Define N as the number of cycles spent in ADD and SHIFT: N = (number of SHIFT cycles) + popcount(bits of Multiplier consumed).
- Accept occurs at edge k. ADD/SHIFT cycles run from k+1 to k+N. Result_valid rises in cycle k+N+1, so the latency is N+1 cycles.
- Start_ready is low from cycle k+1 until the cycle after the DONE→IDLE handshake. Back-to-back throughput is N+2 cycles per multiply when Result_ready is held high.
- Result_valid holds, and Product is stable, while Result_ready is low.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - SHIFT goes to DONE when the shifted mplier is 0 or cnt reaches 32.
  - An accept with Multiplier=0 goes straight to DONE (N=0).
  - SHIFT count equals the index of the highest set bit + 1.
- MUL_EARLY_EXIT_EN undefined:
  - SHIFT goes to DONE only when cnt reaches 32, so there are always 32 SHIFT cycles and N = 32 + popcount(Multiplier).
- The Product value is identical in both builds.

## Structure
- Shared package mul_seq_pkg:
  - state enum {IDLE, ADD, SHIFT, DONE}
  - ALU funct constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_SLL=2'b10, ALU_OR=2'b11
  - DATA_W and ITER_MAX=32
- No sub-module. The ALU is instantiated externally so that it can be shared with the datapath; its funct codes come from the same package constants.

## Test plan
- 3 × 5: Product=15.
  - Without the macro: N=34, Result_valid in cycle k+35.
  - With the macro: N=5 (3 SHIFT, 2 ADD), Result_valid in cycle k+6.
- 0xFFFFFFFF × 0xFFFFFFFF: Product=0x00000001 and N=64 in both builds; check the ALU_funct sequence alternates 00,10 throughout.
- 7 × 0:
  - Without the macro: N=32 with no ADD cycles, Product=0.
  - With the macro: DONE in cycle k+1, Product=0.
- Result_ready held low for 10 cycles in DONE: Result_valid and Product stay stable, Start_ready stays 0, and a Start_valid pulse is ignored.
- rst asserted in cycle k+4 of 0x1234 × 0xFFFF:
  - next cycle: state IDLE, Product=0, Busy=0, Start_ready=1
  - a fresh 2 × 2 then yields 4
- Two back-to-back multiplies (6 × 7, then 9 × 9) with Result_ready high: Product is 42 then 81, and the gap between the two Result_valid pulses equals N₂+2 cycles.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// MUL_EARLY_EXIT_EN: when defined, the loop ends as soon as no multiplier bits remain.
package mul_seq_pkg;

  localparam int DATA_W   = 32;
  localparam int ITER_MAX = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Funct encodings of the shared combinational ALU.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLL = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // First working state after an accepted operand pair.
  function automatic state_t first_state(input logic [DATA_W-1:0] mplier);
    state_t s;
    s = mplier[0] ? ADD : SHIFT;
`ifdef MUL_EARLY_EXIT_EN
    if (mplier == '0) s = DONE;
`endif
    return s;
  endfunction

  // True when the SHIFT just taken is the last one of the multiply.
  function automatic logic loop_finished(input logic [DATA_W-1:0] mplier_next,
                                         input logic [CNT_W-1:0]  cnt_next);
    logic fin;
    fin = (cnt_next == CNT_W'(ITER_MAX));
`ifdef MUL_EARLY_EXIT_EN
    if (mplier_next == '0) fin = 1'b1;
`else
    if (mplier_next[0] && 1'b0) fin = 1'b1;
`endif
    return fin;
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32 (low word) multiplier that borrows an external shared ALU.
// MUL_EARLY_EXIT_EN (see mul_seq_pkg) shortens the loop once the multiplier is exhausted.
module alu_mul_sequencer
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Start_valid,
  output logic              Start_ready,
  input  logic [DATA_W-1:0] Multiplicand,
  input  logic [DATA_W-1:0] Multiplier,
  output logic              Result_valid,
  input  logic              Result_ready,
  output logic [DATA_W-1:0] Product,
  output logic              Busy,
  output logic [DATA_W-1:0] ALU_src_1,
  output logic [DATA_W-1:0] ALU_src_2,
  output logic [4:0]        ALU_shamt,
  output logic [1:0]        ALU_funct,
  input  logic [DATA_W-1:0] ALU_result,
  output state_t            state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. Start_ready is high only in IDLE, Result_valid only in DONE; the other
  // side's valid/ready is ignored in every other state.

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  logic              start_ready_q;
  logic              busy_q;
  logic              result_valid_q;

  state_t            state_next;
  logic [DATA_W-1:0] mplier_shr;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    state_next = state;
    mplier_shr = mplier >> 1;
    cnt_inc    = cnt + 1'b1;
    case (state)
      IDLE:  if (Start_valid) state_next = first_state(Multiplier);
      ADD:   state_next = SHIFT;
      SHIFT: begin
        if (loop_finished(mplier_shr, cnt_inc)) state_next = DONE;
        else                                    state_next = mplier_shr[0] ? ADD : SHIFT;
      end
      DONE:  if (Result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      cnt            <= '0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_next;
      start_ready_q  <= (state_next == IDLE);
      busy_q         <= (state_next == ADD) || (state_next == SHIFT);
      result_valid_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (Start_valid) begin
            mcand  <= Multiplicand;
            mplier <= Multiplier;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ADD: acc <= ALU_result;
        SHIFT: begin
          mcand  <= ALU_result;
          mplier <= mplier_shr;
          cnt    <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  // ALU operands are decoded straight from state so the result lands this cycle.
  always_comb begin
    ALU_src_1 = '0;
    ALU_src_2 = '0;
    ALU_shamt = '0;
    ALU_funct = ALU_ADD;
    case (state)
      ADD: begin
        ALU_src_1 = acc;
        ALU_src_2 = mcand;
        ALU_shamt = 5'd0;
        ALU_funct = ALU_ADD;
      end
      SHIFT: begin
        ALU_src_1 = mcand;
        ALU_src_2 = '0;
        ALU_shamt = 5'd1;
        ALU_funct = ALU_SLL;
      end
      default: ;
    endcase
  end

  assign Start_ready  = start_ready_q;
  assign Busy         = busy_q;
  assign Result_valid = result_valid_q;
  assign Product      = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
// Expected cycle counts follow the MUL_EARLY_EXIT_EN setting of the build.
module tb_alu_mul_sequencer;
  import mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start_valid;
  logic        Start_ready;
  logic [31:0] Multiplicand;
  logic [31:0] Multiplier;
  logic        Result_valid;
  logic        Result_ready;
  logic [31:0] Product;
  logic        Busy;
  logic [31:0] ALU_src_1;
  logic [31:0] ALU_src_2;
  logic [4:0]  ALU_shamt;
  logic [1:0]  ALU_funct;
  logic [31:0] ALU_result;
  state_t      state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  funct_log[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    int          n_full;
    int          n_early;
  } vec_t;

  vec_t vecs[9];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst),
    .Start_valid(Start_valid), .Start_ready(Start_ready),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Result_valid(Result_valid), .Result_ready(Result_ready),
    .Product(Product), .Busy(Busy),
    .ALU_src_1(ALU_src_1), .ALU_src_2(ALU_src_2),
    .ALU_shamt(ALU_shamt), .ALU_funct(ALU_funct),
    .ALU_result(ALU_result), .state(state)
  );

  // Shared ALU model
  always_comb begin
    case (ALU_funct)
      2'b00:   ALU_result = ALU_src_1 + ALU_src_2;
      2'b01:   ALU_result = ALU_src_1 - ALU_src_2;
      2'b10:   ALU_result = ALU_src_1 << ALU_shamt;
      default: ALU_result = ALU_src_1 | ALU_src_2;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_product(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%08h expected none", name, Product);
    end else begin
      e = exp_q.pop_front();
      check(name, Product, e);
    end
  endtask

  // Drive one operand pair; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("start_ready_before_accept", {31'd0, Start_ready}, 32'd1);
    Multiplicand = a;
    Multiplier   = b;
    Start_valid  = 1'b1;
    @(posedge clk);
    #1 Start_valid = 1'b0;
  endtask

  // Count busy cycles until Result_valid; leaves the bench at the DONE negedge.
  task automatic wait_result(output int n, output bit alu_ok, output bit timeout);
    n = 0;
    alu_ok = 1'b1;
    timeout = 1'b1;
    funct_log.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (Result_valid) begin
        timeout = 1'b0;
        break;
      end
      if (!Busy || Start_ready) alu_ok = 1'b0;
      if (ALU_funct == ALU_ADD) begin
        if (ALU_shamt != 5'd0) alu_ok = 1'b0;
      end else if (ALU_funct == ALU_SLL) begin
        if (ALU_shamt != 5'd1 || ALU_src_2 != 32'd0) alu_ok = 1'b0;
      end else begin
        alu_ok = 1'b0;
      end
      funct_log.push_back(ALU_funct);
      n++;
    end
    if (!timeout && {ALU_src_1, ALU_src_2, ALU_shamt, ALU_funct} != '0) alu_ok = 1'b0;
  endtask

  task automatic finish_result();
    Result_ready = 1'b1;
    @(posedge clk);
    #1 Result_ready = 1'b0;
  endtask

  function automatic int exp_n(input vec_t v);
`ifdef MUL_EARLY_EXIT_EN
    return v.n_early;
`else
    return v.n_full;
`endif
  endfunction

  // ---------------- test ----------------
  initial begin
    int  n, adds, t1, t2, cyc;
    bit  alu_ok, to, seq_ok;
    vec_t v;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        34, 5};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  64, 64};
    vecs[2] = '{32'd7,         32'd0,         32'd0,         32, 0};
    vecs[3] = '{32'd6,         32'd7,         32'd42,        35, 6};
    vecs[4] = '{32'd9,         32'd9,         32'd81,        34, 6};
    vecs[5] = '{32'h12345678,  32'h00000010,  32'h23456780,  33, 6};
    vecs[6] = '{32'h80000000,  32'd2,         32'd0,         33, 3};
    vecs[7] = '{32'h0000FFFF,  32'h00010001,  32'hFFFFFFFF,  34, 19};
    vecs[8] = '{32'h80000001,  32'h80000001,  32'h00000001,  34, 34};

    rst = 1'b1;
    Start_valid = 1'b0;
    Result_ready = 1'b0;
    Multiplicand = '0;
    Multiplier = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_start_ready", {31'd0, Start_ready}, 32'd1);
    check("reset_result_valid", {31'd0, Result_valid}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_product", Product, 32'd0);
    check("reset_state", {30'd0, state}, {30'd0, IDLE});
    check("reset_alu", ALU_src_1 | ALU_src_2 | {27'd0, ALU_shamt} | {30'd0, ALU_funct}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      exp_q.push_back(v.p);
      start_op(v.a, v.b);
      wait_result(n, alu_ok, to);
      check($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
      check_product($sformatf("vec%0d_product", i));
      check($sformatf("vec%0d_cycles", i), n, exp_n(v));
      check($sformatf("vec%0d_alu_drive", i), {31'd0, alu_ok}, 32'd1);
      adds = 0;
      seq_ok = 1'b1;
      foreach (funct_log[j]) begin
        if (funct_log[j] == ALU_ADD) adds++;
        if (j > 0 && funct_log[j] == ALU_ADD && funct_log[j-1] == ALU_ADD) seq_ok = 1'b0;
        if (v.b == 32'hFFFFFFFF && funct_log[j] != ((j % 2 == 0) ? ALU_ADD : ALU_SLL)) seq_ok = 1'b0;
      end
      check($sformatf("vec%0d_add_count", i), adds, $countones(v.b));
      check($sformatf("vec%0d_funct_seq", i), {31'd0, seq_ok}, 32'd1);
      finish_result();
    end

    // Result_ready held low in DONE; a stray Start_valid must be ignored
    exp_q.push_back(32'd15);
    start_op(32'd3, 32'd5);
    wait_result(n, alu_ok, to);
    check("hold_timeout", {31'd0, to}, 32'd0);
    check_product("hold_product");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        Multiplicand = 32'd11;
        Multiplier   = 32'd13;
        Start_valid  = 1'b1;
      end
      if (i == 4) Start_valid = 1'b0;
      @(negedge clk);
      check("hold_result_valid", {31'd0, Result_valid}, 32'd1);
      check("hold_product_stable", Product, 32'd15);
      check("hold_start_ready", {31'd0, Start_ready}, 32'd0);
    end
    finish_result();
    @(negedge clk);
    check("hold_back_idle", {30'd0, state}, {30'd0, IDLE});
    check("hold_product_kept", Product, 32'd15);
    check("hold_valid_low", {31'd0, Result_valid}, 32'd0);

    // Reset mid-multiply in cycle k+4
    start_op(32'h1234, 32'hFFFF);
    repeat (4) @(negedge clk);
    check("midrst_partial_acc", Product, 32'h0000369C);
    check("midrst_busy", {31'd0, Busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_state", {30'd0, state}, {30'd0, IDLE});
    check("midrst_product", Product, 32'd0);
    check("midrst_busy_low", {31'd0, Busy}, 32'd0);
    check("midrst_start_ready", {31'd0, Start_ready}, 32'd1);
    check("midrst_result_valid", {31'd0, Result_valid}, 32'd0);
    exp_q.push_back(32'd4);
    start_op(32'd2, 32'd2);
    wait_result(n, alu_ok, to);
    check("after_rst_timeout", {31'd0, to}, 32'd0);
    check_product("after_rst_product");
`ifdef MUL_EARLY_EXIT_EN
    check("after_rst_cycles", n, 3);
`else
    check("after_rst_cycles", n, 33);
`endif
    finish_result();

    // Back-to-back 6x7 then 9x9 with Result_ready held high
    exp_q.push_back(32'd42);
    exp_q.push_back(32'd81);
    @(negedge clk);
    Multiplicand = 32'd6;
    Multiplier   = 32'd7;
    Start_valid  = 1'b1;
    Result_ready = 1'b1;
    @(posedge clk);
    #1;
    Multiplicand = 32'd9;
    Multiplier   = 32'd9;
    t1 = -1;
    t2 = -1;
    cyc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      cyc++;
      if (Result_valid) begin
        if (t1 < 0) begin
          t1 = cyc;
          check_product("b2b_first_product");
        end else begin
          t2 = cyc;
          check_product("b2b_second_product");
          break;
        end
      end else if (t1 >= 0 && Start_ready && Start_valid) begin
        @(posedge clk);
        #1 Start_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 Result_ready = 1'b0;
    Start_valid = 1'b0;
    check("b2b_timeout", {31'd0, (t1 < 0 || t2 < 0)}, 32'd0);
    v = vecs[4];
    check("b2b_gap", t2 - t1, exp_n(v) + 2);
    @(negedge clk);
    check("b2b_idle", {30'd0, state}, {30'd0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
